// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined ripple-carry adder. A DATA_WIDTH-bit addition is split into STAGES
// equal slices of CHUNK = DATA_WIDTH/STAGES bits. Stage k adds slice k and
// registers the partial sum and the carry into stage k+1. The operands travel
// with the beat so that later stages can still reach their upper slices. Each
// stage has its own valid bit, so the pipeline can hold bubbles.
// Backpressure is global: when the output holds a result the consumer has not
// taken, no pipeline register moves.
//
// DATA_WIDTH must be divisible by STAGES.
//
// Optional feature: define PIPELINED_ADDER_SUB_EN to add the `sub` input.
// With sub=1 the beat computes a - b - cin: the stage logic uses ~b, and the
// bit-0 carry-in becomes !cin. In that mode sum[DATA_WIDTH]=1 means no borrow.
//
// Ports:
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (= !stall, combinational)
//   a, b       operands, DATA_WIDTH bits
//   cin        carry-in to bit 0
//   sub        (PIPELINED_ADDER_SUB_EN only) subtract select, sampled per beat
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        DATA_WIDTH+1 bit result; the MSB is the final carry-out
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   sum
);

  localparam int CHUNK = DATA_WIDTH / STAGES;

  logic stall;
  logic sub_w;

`ifdef PIPELINED_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Pipeline registers, one entry per stage.
  logic [STAGES-1:0]     vld_q;
  logic [STAGES-1:0]     cry_q;
  logic [STAGES-1:0]     sub_q;
  logic [DATA_WIDTH-1:0] a_q  [STAGES];
  logic [DATA_WIDTH-1:0] b_q  [STAGES];
  logic [DATA_WIDTH-1:0] ps_q [STAGES];  // result slices produced so far

  // Stage inputs: stage 0 takes the ports, stage k takes stage k-1's registers.
  logic [STAGES-1:0]     vld_in;
  logic [STAGES-1:0]     cry_in;
  logic [STAGES-1:0]     sub_in;
  logic [DATA_WIDTH-1:0] a_in  [STAGES];
  logic [DATA_WIDTH-1:0] b_in  [STAGES];
  logic [DATA_WIDTH-1:0] ps_in [STAGES];

  // Stage results.
  logic [STAGES-1:0]     cry_nx;
  logic [DATA_WIDTH-1:0] ps_nx [STAGES];

  assign out_valid = vld_q[STAGES-1];
  assign sum       = {cry_q[STAGES-1], ps_q[STAGES-1]};
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // NOTE: every variable written here gets a value on every pass, stage 0 from
  // the ports and the loop for the rest, so no latch is inferred.
  always_comb begin
    vld_in[0] = in_valid;
    a_in[0]   = a;
    b_in[0]   = b;
    sub_in[0] = sub_w;
    // Subtraction is a + ~b + 1; with a borrow-in the +1 goes away, so the
    // bit-0 carry is cin inverted when sub is set.
    cry_in[0] = cin ^ sub_w;
    ps_in[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      sub_in[k] = sub_q[k-1];
      cry_in[k] = cry_q[k-1];
      ps_in[k]  = ps_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      logic [CHUNK-1:0] op_b;
      logic [CHUNK:0]   slice;
      op_b  = b_in[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_in[k]}};
      slice = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, op_b}
              + (CHUNK+1)'(cry_in[k]);
      // Slices above k are still zero in ps_in, so OR merges the new slice in.
      ps_nx[k]  = ps_in[k] | (DATA_WIDTH'(slice[CHUNK-1:0]) << (k*CHUNK));
      cry_nx[k] = slice[CHUNK];
    end
  end

  // NOTE: the datapath registers are reset along with the valids, so that sum
  // reads 0 during reset and no stale slice from before reset can reach the
  // output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      cry_q <= '0;
      sub_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        ps_q[k] <= '0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments, so every stage shifts from the values
      // the stages held before this edge.
      vld_q <= vld_in;
      cry_q <= cry_nx;
      sub_q <= sub_in;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_in[k];
        b_q[k]  <= b_in[k];
        ps_q[k] <= ps_nx[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Self-checking bench for pipelined_adder. dut is 8 bits wide with 2 stages.
// dut4 is 32 bits wide with 4 stages and checks that the latency grows with
// STAGES. The bench drives inputs on the falling edge and samples just after.
// Subtraction checks are compiled only when PIPELINED_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int W4 = 32;
  localparam int S4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic          in_valid, in_ready, cin, out_valid, out_ready, sub;
  logic [W-1:0]  a, b;
  logic [W:0]    sum;

  logic          in_valid4, in_ready4, cin4, out_valid4, out_ready4, sub4;
  logic [W4-1:0] a4, b4;
  logic [W4:0]   sum4;

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.DATA_WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  pipelined_adder #(.DATA_WIDTH(W4), .STAGES(S4)) dut4 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat through dut: checks latency, the value, and that it
  // appears exactly once.
  task automatic beat8(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic [W:0] exp);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c < S; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(exp));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_once"}, 64'(out_valid), 64'd0);
  endtask

  // The same for dut4. Only the final latency cycle is checked on value.
  task automatic beat32(input string tag, input logic [W4-1:0] ta, input logic [W4-1:0] tb_,
                        input logic tc, input logic ts, input logic [W4:0] exp);
    @(negedge clk);
    in_valid4 = 1'b1; a4 = ta; b4 = tb_; cin4 = tc; sub4 = ts; out_ready4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c < S4; c++) begin
      @(negedge clk);
      in_valid4 = 1'b0;
      check($sformatf("%s_early%0d", tag, c), 64'(out_valid4), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    check({tag, "_valid"}, 64'(out_valid4), 64'd1);
    check({tag, "_sum"}, 64'(sum4), 64'(exp));
  endtask

  // Streams n beats into dut. out_ready is held low for the first `hold`
  // cycles. A scoreboard holds the reference sums in input order.
  task automatic stream(input string tag, input int n, input int hold, input int seed);
    logic [W:0]   q[$];
    logic [W:0]   prev_sum;
    logic [W:0]   e;
    logic [W-1:0] ta, tb_;
    logic         tc;
    logic         prev_stall;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_sum = '0;
    ta = '0; tb_ = '0; tc = 1'b0;
    while (got < n && cyc < n + hold + 20) begin
      @(negedge clk);
      out_ready = (cyc >= hold);
      sub = 1'b0;
      if (sent < n) begin
        ta  = 8'((sent + seed) * 29 + 7);
        tb_ = 8'((sent + seed) * 83 + 200);
        tc  = 1'((sent + seed) & 1);
        in_valid = 1'b1; a = ta; b = tb_; cin = tc;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall)
        check({tag, "_hold"}, 64'({out_valid, sum}), 64'({1'b1, prev_sum}));
      if (out_ready)
        check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
      else if (out_valid)
        check({tag, "_inrdy_low"}, 64'(in_ready), 64'd0);
      if (hold == 0 && got > 0)
        check({tag, "_gap"}, 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_extra"}, 64'd1, 64'd0);
        end else begin
          check($sformatf("%s_res%0d", tag, got), 64'(sum), 64'(q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e = {1'b0, ta} + {1'b0, tb_} + 9'(tc);
        q.push_back(e);
        sent++;
      end
      if (hold > 0 && cyc == hold - 1)
        check({tag, "_fill"}, 64'(sent), 64'(S));
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;

    #3;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_inrdy", 64'(in_ready), 64'd1);
    check("reset_valid4", 64'(out_valid4), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Carry crosses the slice boundary.
    beat8("single", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);
    // Overflow with carry-in, and carry out of the top slice only.
    beat8("ovf_cin", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    beat8("ovf_msb", 8'h80, 8'h80, 1'b0, 1'b0, 9'h100);

    stream("stream", 16, 0, 0);
    stream("bp", 6, 6, 40);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(negedge clk);
    a = 8'h55; b = 8'h66;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_sum", 64'(sum), 64'd0);
    check("rst_mid_inrdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_stale%0d", c), 64'(out_valid), 64'd0);
    end
    beat8("rst_next", 8'h03, 8'h04, 1'b0, 1'b0, 9'h007);

    // Wide instance: the carry ripples through every slice, latency 4.
    beat32("wide_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000);
    beat32("wide_cin", 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 33'h0_2222_2221);

`ifdef PIPELINED_ADDER_SUB_EN
    beat8("sub_nb", 8'h05, 8'h03, 1'b0, 1'b1, 9'h102);
    beat8("sub_b", 8'h03, 8'h05, 1'b0, 1'b1, 9'h0FE);
    beat8("sub_bin", 8'h05, 8'h03, 1'b1, 1'b1, 9'h101);
    beat32("sub4_nb", 32'h5, 32'h3, 1'b0, 1'b1, 33'h1_0000_0002);
    beat32("sub4_b", 32'h3, 32'h5, 1'b0, 1'b1, 33'h0_FFFF_FFFE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
